// File: rtl/canvas_write_scheduler_pkg.sv
// Shared definitions for the canvas write scheduler.
//   COLOR_WIDTH   : bit width of one pixel colour
//   COLOR_*       : named colour constants (COLOR_NONE is the idle/reset colour)
//   sched_state_t : scheduler state (IDLE arbitrates, CLEAR sweeps the frame)
package canvas_write_scheduler_pkg;

    localparam int COLOR_WIDTH = 24;

    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 24'h00_00_00;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 24'hFF_FF_FF;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 24'hFF_00_00;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 24'h00_FF_00;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 24'h00_00_FF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sched_state_t;

endpackage

// File: rtl/canvas_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches ptr+1, ptr+2, ... modulo N and grants the first requesting index.
// Ports:
//   req       : request vector
//   ptr       : index granted last (search starts just after it)
//   grant     : one-hot grant, all zero when no request
//   grant_idx : binary index of the granted requester (0 when no grant)
module rr_arbiter
    import canvas_write_scheduler_pkg::*;
#(
    parameter int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [N-1:0]  grant_s;
    logic [PW-1:0] grant_idx_s;
    logic [PW-1:0] cand_s;
    logic          found_s;

    // Rotating priority search starting one past the last granted index
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        cand_s      = '0;
        found_s     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand_s = PW'((int'(ptr) + i) % N);
            if (!found_s && req[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                grant_idx_s     = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;

endmodule

// File: rtl/canvas_write_scheduler.sv
// Canvas write scheduler: shares one frame-buffer write port between NUM_REQ
// pixel writers using round-robin arbitration, plus a full-frame clear
// sequencer that pre-empts all writers while it sweeps.
// Optional build macro: CANVAS_SCHED_CLIP_EN -- when defined, granted requests
// whose coordinates fall outside the frame are accepted but not written.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/x/y/color    : packed per-requester write requests (i at [i*W +: W])
//   req_ready              : one-hot combinational grant
//   clear_start/clear_color: start pulse and colour for a full-frame clear
//   clear_busy, clear_done : registered sweep status and completion pulse
//   wr_en/x/y/color        : registered frame-buffer write (1 cycle after accept)
module canvas_write_scheduler
    import canvas_write_scheduler_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int NUM_REQ = 3,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*XW-1:0]          req_x,
    input  logic [NUM_REQ*YW-1:0]          req_y,
    input  logic [NUM_REQ*COLOR_WIDTH-1:0] req_color,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           clear_start,
    input  logic [COLOR_WIDTH-1:0]         clear_color,
    output logic                           clear_busy,
    output logic                           clear_done,
    output logic                           wr_en,
    output logic [XW-1:0]                  wr_x,
    output logic [YW-1:0]                  wr_y,
    output logic [COLOR_WIDTH-1:0]         wr_color
);

    sched_state_t           state_r, state_n;
    logic [PW-1:0]          rr_ptr_r, rr_ptr_n;
    logic [XW-1:0]          cx_r, cx_n;
    logic [YW-1:0]          cy_r, cy_n;
    logic [COLOR_WIDTH-1:0] clear_color_r, clear_color_n;
    logic                   wr_en_r, wr_en_n;
    logic [XW-1:0]          wr_x_r, wr_x_n;
    logic [YW-1:0]          wr_y_r, wr_y_n;
    logic [COLOR_WIDTH-1:0] wr_color_r, wr_color_n;
    logic                   clear_busy_r, clear_busy_n;
    logic                   clear_done_r, clear_done_n;

    logic [NUM_REQ-1:0]     grant_s;
    logic [PW-1:0]          grant_idx_s;
    logic [NUM_REQ-1:0]     ready_s;
    logic [XW-1:0]          sel_x_s;
    logic [YW-1:0]          sel_y_s;
    logic [COLOR_WIDTH-1:0] sel_color_s;
    logic                   in_range_s;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Mux out the granted requester's pixel and decide whether it is writable
    always_comb begin
        sel_x_s     = req_x[grant_idx_s*XW +: XW];
        sel_y_s     = req_y[grant_idx_s*YW +: YW];
        sel_color_s = req_color[grant_idx_s*COLOR_WIDTH +: COLOR_WIDTH];
`ifdef CANVAS_SCHED_CLIP_EN
        // One extra bit so the compare stays exact when WIDTH/HEIGHT are powers of two
        in_range_s  = ({1'b0, sel_x_s} < (XW+1)'(WIDTH)) &&
                      ({1'b0, sel_y_s} < (YW+1)'(HEIGHT));
`else
        in_range_s  = 1'b1;
`endif
    end

    // Next-state, grant and write-port logic
    always_comb begin
        state_n       = state_r;
        rr_ptr_n      = rr_ptr_r;
        cx_n          = cx_r;
        cy_n          = cy_r;
        clear_color_n = clear_color_r;
        wr_en_n       = 1'b0;
        wr_x_n        = wr_x_r;
        wr_y_n        = wr_y_r;
        wr_color_n    = wr_color_r;
        clear_done_n  = 1'b0;
        ready_s       = '0;

        case (state_r)
            IDLE: begin
                if (clear_start) begin
                    // Clear wins over any pending request this cycle
                    state_n       = CLEAR;
                    clear_color_n = clear_color;
                    cx_n          = '0;
                    cy_n          = '0;
                end else if (|grant_s) begin
                    ready_s  = grant_s;
                    rr_ptr_n = grant_idx_s;
                    if (in_range_s) begin
                        wr_en_n    = 1'b1;
                        wr_x_n     = sel_x_s;
                        wr_y_n     = sel_y_s;
                        wr_color_n = sel_color_s;
                    end else begin
                        wr_en_n = 1'b0;
                    end
                end else begin
                    ready_s = '0;
                end
            end
            CLEAR: begin
                wr_en_n    = 1'b1;
                wr_x_n     = cx_r;
                wr_y_n     = cy_r;
                wr_color_n = clear_color_r;
                // Explicit wrap compares: frame dimensions need not be powers of two
                if (cx_r == XW'(WIDTH - 1)) begin
                    cx_n = '0;
                    if (cy_r == YW'(HEIGHT - 1)) begin
                        cy_n         = '0;
                        state_n      = IDLE;
                        clear_done_n = 1'b1;
                    end else begin
                        cy_n = cy_r + YW'(1);
                    end
                end else begin
                    cx_n = cx_r + XW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        clear_busy_n = (state_n == CLEAR);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            rr_ptr_r      <= PW'(NUM_REQ - 1);
            cx_r          <= '0;
            cy_r          <= '0;
            clear_color_r <= COLOR_NONE;
            wr_en_r       <= 1'b0;
            wr_x_r        <= '0;
            wr_y_r        <= '0;
            wr_color_r    <= COLOR_NONE;
            clear_busy_r  <= 1'b0;
            clear_done_r  <= 1'b0;
        end else begin
            state_r       <= state_n;
            rr_ptr_r      <= rr_ptr_n;
            cx_r          <= cx_n;
            cy_r          <= cy_n;
            clear_color_r <= clear_color_n;
            wr_en_r       <= wr_en_n;
            wr_x_r        <= wr_x_n;
            wr_y_r        <= wr_y_n;
            wr_color_r    <= wr_color_n;
            clear_busy_r  <= clear_busy_n;
            clear_done_r  <= clear_done_n;
        end
    end

    assign req_ready  = ready_s;
    assign wr_en      = wr_en_r;
    assign wr_x       = wr_x_r;
    assign wr_y       = wr_y_r;
    assign wr_color   = wr_color_r;
    assign clear_busy = clear_busy_r;
    assign clear_done = clear_done_r;

endmodule

// File: tb/tb_canvas_write_scheduler.sv
// Scoreboard bench for canvas_write_scheduler (WIDTH=8, HEIGHT=4, NUM_REQ=3).
// Stimulus pushes expected writes (with the cycle they must appear in) into a
// queue; a monitor pops and compares on every wr_en.
module tb_canvas_write_scheduler;
    import canvas_write_scheduler_pkg::*;

    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 4;
    localparam int NUM_REQ = 3;
    localparam int XW      = 3;
    localparam int YW      = 2;
    localparam int CW      = COLOR_WIDTH;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        int            cyc;
    } wr_exp_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*XW-1:0]  req_x;
    logic [NUM_REQ*YW-1:0]  req_y;
    logic [NUM_REQ*CW-1:0]  req_color;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   clear_start;
    logic [CW-1:0]          clear_color;
    logic                   clear_busy;
    logic                   clear_done;
    logic                   wr_en;
    logic [XW-1:0]          wr_x;
    logic [YW-1:0]          wr_y;
    logic [CW-1:0]          wr_color;

    int      checks = 0;
    int      errors = 0;
    int      cyc    = 0;
    wr_exp_t exp_q[$];

    canvas_write_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected writes
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [CW-1:0] c);
        req_x[i*XW +: XW] = x;
        req_y[i*YW +: YW] = y;
        req_color[i*CW +: CW] = c;
    endtask

    task automatic push_wr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [CW-1:0] c, input int at);
        wr_exp_t e;
        e.x = x; e.y = y; e.c = c; e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Push the 32 writes of a full sweep, the first appearing two cycles later
    task automatic push_clear(input logic [CW-1:0] c);
        for (int j = 0; j < WIDTH*HEIGHT; j++)
            push_wr(XW'(j % WIDTH), YW'(j / WIDTH), c, cyc + 2 + j);
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got x=%0d y=%0d c=0x%0h at cycle %0d, expected no write",
                         wr_x, wr_y, wr_color, cyc);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                if (wr_x !== e.x || wr_y !== e.y || wr_color !== e.c || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL wr_data: got x=%0d y=%0d c=0x%0h cyc=%0d, expected x=%0d y=%0d c=0x%0h cyc=%0d",
                             wr_x, wr_y, wr_color, cyc, e.x, e.y, e.c, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0] g;
        logic [XW-1:0]      x6;
        logic               clip6;

        reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_color = '0;
        clear_start = 1'b0; clear_color = COLOR_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_x", 32'(wr_x), 32'd0);
        check("rst_wr_color", 32'(wr_color), 32'(COLOR_NONE));
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        tick();
        reset = 1'b0;

        // 1: all requesters valid -> 0,1,2,0,1,2
        set_req(0, 3'd1, 2'd0, COLOR_RED);
        set_req(1, 3'd2, 2'd1, COLOR_GREEN);
        set_req(2, 3'd4, 2'd3, COLOR_WHITE);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g = 3'b001 << (k % 3);
            case (k % 3)
                0: push_wr(3'd1, 2'd0, COLOR_RED, cyc + 1);
                1: push_wr(3'd2, 2'd1, COLOR_GREEN, cyc + 1);
                default: push_wr(3'd4, 2'd3, COLOR_WHITE, cyc + 1);
            endcase
            @(negedge clk);
            check("t1_ready", 32'(req_ready), 32'(g));
            tick();
        end
        req_valid = '0;
        tick();

        // 2: single requester 1
        set_req(1, 3'd3, 2'd2, COLOR_BLUE);
        req_valid = 3'b010;
        push_wr(3'd3, 2'd2, COLOR_BLUE, cyc + 1);
        @(negedge clk);
        check("t2_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("t2_wr_en_low", 32'(wr_en), 32'd0);
        check("t2_wr_x_hold", 32'(wr_x), 32'd3);
        tick();

        // 3: clear beats simultaneous request; req 0 granted afterwards
        set_req(0, 3'd5, 2'd1, COLOR_RED);
        req_valid = 3'b001;
        clear_start = 1'b1; clear_color = COLOR_NONE;
        push_clear(COLOR_NONE);
        @(negedge clk);
        check("t3_no_grant", 32'(req_ready), 32'd0);
        tick();
        clear_start = 1'b0;
        for (int j = 0; j < WIDTH*HEIGHT; j++) begin
            @(negedge clk);
            check("t3_busy", 32'(clear_busy), 32'd1);
            check("t3_ready_blocked", 32'(req_ready), 32'd0);
            check("t3_done_early", 32'(clear_done), 32'd0);
            tick();
        end
        push_wr(3'd5, 2'd1, COLOR_RED, cyc + 1);
        @(negedge clk);
        check("t3_done", 32'(clear_done), 32'd1);
        check("t3_busy_fall", 32'(clear_busy), 32'd0);
        check("t3_ready_after", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t3_done_pulse", 32'(clear_done), 32'd0);
        tick();

        // 4: clear_start mid-sweep is ignored
        clear_start = 1'b1; clear_color = COLOR_WHITE;
        push_clear(COLOR_WHITE);
        tick();
        for (int j = 0; j < WIDTH*HEIGHT; j++) begin
            clear_start = (j == 10);
            clear_color = (j == 10) ? COLOR_RED : COLOR_WHITE;
            @(negedge clk);
            check("t4_busy", 32'(clear_busy), 32'd1);
            tick();
        end
        clear_start = 1'b0;
        @(negedge clk);
        check("t4_done", 32'(clear_done), 32'd1);
        tick();
        @(negedge clk);
        check("t4_idle", 32'(clear_busy), 32'd0);
        tick();

        // 5: reset at pixel 15 aborts the sweep without clear_done
        clear_start = 1'b1; clear_color = COLOR_GREEN;
        push_clear(COLOR_GREEN);
        tick();
        clear_start = 1'b0;
        for (int j = 0; j < 15; j++) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("t5_wr_en", 32'(wr_en), 32'd0);
        check("t5_busy", 32'(clear_busy), 32'd0);
        check("t5_done", 32'(clear_done), 32'd0);
        check("t5_wr_x", 32'(wr_x), 32'd0);
        check("t5_pending", 32'(exp_q.size()), 32'd17);
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("t5_no_done", 32'(clear_done), 32'd0);
            tick();
        end
        set_req(0, 3'd6, 2'd2, COLOR_RED);
        set_req(1, 3'd7, 2'd3, COLOR_GREEN);
        req_valid = 3'b011;
        push_wr(3'd6, 2'd2, COLOR_RED, cyc + 1);
        @(negedge clk);
        check("t5_grant", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        tick();

        // 6: x=9 truncates to 1 in an XW=3 port; write unless clipped
        x6 = XW'(9);
`ifdef CANVAS_SCHED_CLIP_EN
        clip6 = (int'(x6) >= WIDTH);
`else
        clip6 = 1'b0;
`endif
        set_req(2, x6, 2'd1, COLOR_BLUE);
        req_valid = 3'b100;
        if (!clip6) push_wr(3'd1, 2'd1, COLOR_BLUE, cyc + 1);
        @(negedge clk);
        check("t6_ready", 32'(req_ready), 32'b100);
        tick();
        // pointer now at 2, so 0 wins next with everyone valid
        set_req(0, 3'd2, 2'd3, COLOR_WHITE);
        req_valid = 3'b111;
        push_wr(3'd2, 2'd3, COLOR_WHITE, cyc + 1);
        @(negedge clk);
        check("t6_ptr_next", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
